regfile: RTL and testbench
==========================

Name: regfile

Overview:
- RV32I integer register file: 32 general-purpose registers x0..x31, each DATA_W bits wide.
- Provides two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Sits in the decode stage of the core. Read data feeds the ALU and branch operands; the write port is driven by writeback.
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register index width; number of registers = 2**ADDR_W.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low; sampled on the rising edge of clk_i.
- reg_write_i  in  1  write enable for the rd port.
- rs1_i  in  ADDR_W  read port 1 register index.
- rs2_i  in  ADDR_W  read port 2 register index.
- rd_i  in  ADDR_W  write port register index.
- write_data_i  in  DATA_W  data to write into register rd_i.
- rs1_data_o  out  DATA_W  contents of register rs1_i (combinational).
- rs2_data_o  out  DATA_W  contents of register rs2_i (combinational).

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_n_i is synchronous and active-low. The reset value is loaded at a rising edge of clk_i while rst_n_i=0. There is no asynchronous clear.
- Storage: registers 1..2**ADDR_W-1 are flops. There is no storage for x0.
- Reset:
  - At any rising edge with rst_n_i=0, every register is cleared to 0.
  - Reset has priority over a simultaneous write.
  - While rst_n_i=0, rs1_data_o and rs2_data_o are forced to 0, so outputs are deterministic before the first reset edge.
  - Reset asserted in the middle of a write sequence discards the pending write.
- Write:
  - At a rising edge with rst_n_i=1, reg_write_i=1 and rd_i!=0, reg[rd_i] <= write_data_i.
  - Writes to rd_i=0 are ignored.
  - With reg_write_i=0, no register changes.
- Read:
  - Purely combinational, zero-cycle latency.
  - rsN_data_o = 0 when rsN_i=0; otherwise it equals reg[rsN_i].
  - Both ports are independent; they may address the same register simultaneously.
- Write-through bypass:
  - When reg_write_i=1, rd_i!=0, rst_n_i=1 and rsN_i==rd_i, rsN_data_o = write_data_i in the same cycle.
  - This returns the new value before the clock edge, so the decode stage sees same-cycle writeback data.
  - The bypass applies to each port independently and is never applied for index 0.
- Write then read:
  - After the write edge, a read of the written register returns the new value.
  - The value is held indefinitely until the next write to that register or reset.
- Width: there is no arithmetic, and indices are used unmodified. Out-of-range indices are impossible (the port is exactly ADDR_W bits wide).
- No X propagation from outputs after the first reset edge.

Decomposition:
- Shared core package holds:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32;
  - typedefs reg_addr_t [REG_ADDR_W-1:0] and xlen_t [XLEN-1:0];
  - constant REG_ZERO=5'd0.
- The parameter defaults are taken from the package.
- One natural sub-module, regfile_read_port:
  - inputs: index, storage array view, write-port signals, reset;
  - output: the selected read data;
  - contains the zero-index, reset-force and bypass muxing;
  - instantiated twice, once for rs1 and once for rs2.
- Storage and write logic live in the top module.

Test Plan:
- Reset: hold rst_n_i=0 for one edge, then release; read rs1_i=1..31 and rs2_i=31..1 -> all outputs 0. While rst_n_i=0, outputs are 0 regardless of the index.
- Basic write/read, port 1: write rd_i=1, write_data_i=32'hDEADBEEF, reg_write_i=1 for one edge; deassert; set rs1_i=1 -> rs1_data_o=32'hDEADBEEF. It still reads DEADBEEF 5 cycles later.
- Basic write/read, port 2: write rd_i=2 with 32'hCAFEBABE; set rs2_i=2 -> rs2_data_o=32'hCAFEBABE. Register x1 still reads DEADBEEF on rs1.
- x0 hardwired: write rd_i=0 with 32'hFFFFFFFF; set rs1_i=0 and rs2_i=0 -> both outputs 0. Disabled write: reg_write_i=0, rd_i=3, data 32'h12345678 -> x3 stays 0.
- Bypass and dual-port read: with x5=32'h11111111, drive rd_i=5, write_data_i=32'h22222222, reg_write_i=1 and rs1_i=rs2_i=5 before the edge -> both outputs read 32'h22222222 in the same cycle. After the edge with reg_write_i=0, both still read 32'h22222222.
- Reset priority: rst_n_i=0 and reg_write_i=1 with rd_i=1, data 32'hA5A5A5A5 on the same edge -> x1 reads 0 after reset releases. Writes to all 31 registers with unique values (e.g. 32'h1000_0000+i), followed by readback on both ports -> no aliasing.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared core definitions for the RV32I integer register file.
// Holds the architectural widths, their typedefs and the x0 index constant.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Resolves the x0, reset-force and same-cycle write-through cases before the array lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                                  rst_n_i,
  input  logic [ADDR_W-1:0]                     idx_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    regs_i,
  input  logic                                  reg_write_i,
  input  logic [ADDR_W-1:0]                     rd_i,
  input  logic [DATA_W-1:0]                     write_data_i,
  output logic [DATA_W-1:0]                     data_o
);

  // NOTE: assign a default before any branch so this block can never infer a latch.
  always_comb begin
    data_o = '0;
    if (!rst_n_i) begin
      data_o = '0;
    end else if (idx_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end else if (reg_write_i && (rd_i == idx_i)) begin
      // idx_i is known non-zero here, so the bypass never applies to x0.
      data_o = write_data_i;
    end else begin
      data_o = regs_i[idx_i];
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile.sv
// RV32I integer register file: 31 flop registers plus hardwired x0,
// two combinational read ports with write-through bypass and one write port.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0]             regs [1:NREGS-1];
  logic [NREGS-1:0][DATA_W-1:0]  reg_view;
  logic                          wr_en;

  assign wr_en = reg_write_i && (rd_i != ADDR_W'(REG_ZERO));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: this array is built from flops (not a RAM macro), so it can and must be cleared on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_i == ADDR_W'(i)) begin
          regs[i] <= write_data_i;
        end
      end
    end
  end

  // Flattened view for the read ports; entry 0 is a constant, not storage.
  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      reg_view[i] = regs[i];
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs1_port (
    .rst_n_i      (rst_n_i),
    .idx_i        (rs1_i),
    .regs_i       (reg_view),
    .reg_write_i  (reg_write_i),
    .rd_i         (rd_i),
    .write_data_i (write_data_i),
    .data_o       (rs1_data_o)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs2_port (
    .rst_n_i      (rst_n_i),
    .idx_i        (rs2_i),
    .regs_i       (reg_view),
    .reg_write_i  (reg_write_i),
    .rd_i         (rd_i),
    .write_data_i (write_data_i),
    .data_o       (rs2_data_o)
  );

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand sequences,
// then randomized traffic against an array-based reference model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] write_data_i = '0;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[$];

  regfile dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .reg_write_i  (reg_write_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rd_i         (rd_i),
    .write_data_i (write_data_i),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle (inputs settle mid-low-phase), check the pre-edge
  // outputs, then let the edge happen and advance the reference model.
  task automatic cycle(input string name, input logic rst_n, input logic we,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] exp1, input logic [31:0] exp2);
    rst_n_i      = rst_n;
    reg_write_i  = we;
    rd_i         = rd;
    write_data_i = wd;
    rs1_i        = rs1;
    rs2_i        = rs2;
    #1;
    check({name, ".rs1"}, rs1_data_o, exp1);
    check({name, ".rs2"}, rs2_data_o, exp2);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && rd != 5'd0) begin
      model[rd] = wd;
    end
    @(negedge clk);
  endtask

  // Expected read value straight from the architectural rules.
  function automatic logic [31:0] ref_read(input logic rst_n, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wd,
                                           input logic [4:0] rs);
    if (!rst_n || rs == 5'd0) return 32'h0;
    if (we && rd == rs) return wd;
    return model[rs];
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic we, input logic [4:0] rd,
                              input logic [31:0] wd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] exp1, input logic [31:0] exp2);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.rd = rd; v.wd = wd;
    v.rs1 = rs1; v.rs2 = rs2; v.exp1 = exp1; v.exp2 = exp2;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);

    // Reset edge with a competing write; outputs forced to 0 before any reset edge.
    cycle("pre_reset", 1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 5'd7, 5'd1, 32'h0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      cycle("reset_clear", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 32'h0, 32'h0);
    end

    vecs.push_back(mk(1, 1, 5'd1, 32'hDEADBEEF, 5'd0, 5'd3, 32'h0, 32'h0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd1, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 5'd2, 32'hCAFEBABE, 5'd1, 5'd4, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd1, 5'd2, 32'hDEADBEEF, 32'hCAFEBABE));
    vecs.push_back(mk(1, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 5'd3, 32'h12345678, 5'd3, 5'd3, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd3, 5'd0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, 5'd5, 32'h11111111, 5'd1, 5'd2, 32'hDEADBEEF, 32'hCAFEBABE));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd5, 5'd0, 32'h11111111, 32'h0));
    vecs.push_back(mk(1, 1, 5'd5, 32'h22222222, 5'd5, 5'd5, 32'h22222222, 32'h22222222));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h22222222, 32'h22222222));
    vecs.push_back(mk(1, 1, 5'd7, 32'h77777777, 5'd7, 5'd1, 32'h77777777, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd5, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd1, 5'd5, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 5'd0, 32'h0, 5'd7, 5'd2, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].we, vecs[i].rd, vecs[i].wd,
            vecs[i].rs1, vecs[i].rs2, vecs[i].exp1, vecs[i].exp2);
    end

    // Unique value in every register, then cross-read on both ports.
    for (int i = 1; i < 32; i++) begin
      cycle("fill", 1'b1, 1'b1, 5'(i), 32'h1000_0000 + i, 5'(i), 5'd0, 32'h1000_0000 + i, 32'h0);
    end
    for (int i = 1; i < 32; i++) begin
      cycle("fill_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i),
            32'h1000_0000 + i, 32'h1000_0000 + (32 - i));
    end

    // Randomized traffic, with occasional resets landing mid-sequence.
    for (int n = 0; n < 400; n++) begin
      logic        r_rst, r_we;
      logic [4:0]  r_rd, r_rs1, r_rs2;
      logic [31:0] r_wd;
      r_rst = ($urandom_range(0, 39) != 0);
      r_we  = $urandom_range(0, 2) != 0;
      r_rd  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_rs1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_rs2 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      cycle("rand", r_rst, r_we, r_rd, r_wd, r_rs1, r_rs2,
            ref_read(r_rst, r_we, r_rd, r_wd, r_rs1),
            ref_read(r_rst, r_we, r_rd, r_wd, r_rs2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile
